pwm_rom_sequencer: RTL and testbench
====================================

Name: pwm_rom_sequencer

Overview:
- Steps through a duty-cycle table held in the ROM block and drives a single PWM output from it.
- Owns the ROM's chip-enable, read-enable and address lines, and fetches one entry per step.
- Holds each entry for a fixed number of PWM periods, then advances to the next entry.
- Sits between the ROM and the PWM output pin, and is started and stopped by an enable from top-level control.

Parameters:
- DATA_WIDTH, 8: width of a ROM entry. Also sets the PWM counter width, so period = 2**DATA_WIDTH clocks.
- ADDRESS_WIDTH, 8: ROM address width. The table spans addresses 0..2**ADDRESS_WIDTH-1.
- PERIODS_PER_STEP, 4: number of full PWM periods each entry is held (>=1).

Ports:
- clk  in  1: system clock, rising edge.
- rst  in  1: reset, synchronous, active-high.
- enable  in  1: run request. Level-sensitive.
- loop_en  in  1: 1 = wrap to address 0 after the last entry; 0 = stop after the last entry.
- rom_ce  out  1: ROM chip enable.
- rom_read_en  out  1: ROM read enable.
- rom_address  out  ADDRESS_WIDTH: ROM address.
- rom_data  in  DATA_WIDTH: ROM read data. Combinational from the address.
- pwm_out  out  1: PWM output.
- duty  out  DATA_WIDTH: duty value currently in use.
- busy  out  1: high in FETCH or RUN.
- done  out  1: high in DONE.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: every output 0; state = IDLE; address, counter, period count and duty register all 0.
- States: IDLE, FETCH, RUN, DONE. All outputs are registered.
- IDLE:
  - Outputs are low.
  - enable=1 -> FETCH with rom_address=0.
- FETCH (exactly 1 cycle):
  - rom_ce = rom_read_en = 1.
  - rom_data is captured into duty at the end of the cycle.
  - pwm counter and period count are cleared.
  - Next state is RUN.
  - rom_ce and rom_read_en are low in every other state.
- RUN:
  - The counter increments every cycle from 0 to 2**DATA_WIDTH-1 and wraps.
  - pwm_out = (counter < duty), registered so it aligns with the counter value.
  - duty=0 -> pwm_out is never high.
  - duty=max -> pwm_out is high for max of every 2**DATA_WIDTH cycles.
- Period accounting:
  - The period count increments on each counter wrap.
  - On the wrap that completes period PERIODS_PER_STEP-1, the step ends.
  - If address < last: address+1, go to FETCH.
  - If address == last and loop_en=1: address wraps to 0, go to FETCH.
  - If address == last and loop_en=0: go to DONE.
  - loop_en is sampled only at that wrap.
- Step timing: 1 FETCH cycle + PERIODS_PER_STEP*2**DATA_WIDTH RUN cycles. pwm_out is 0 during FETCH.
- DONE:
  - done=1, pwm_out=0. done stays high while enable=1.
  - enable=0 -> IDLE.
- enable=0 in FETCH or RUN aborts the run:
  - Next cycle the state is IDLE, pwm_out=0, address=0.
  - There is no completion of the current period.
- Reset during any state forces the reset values on the next edge, overriding enable.
- Address arithmetic is unsigned modulo 2**ADDRESS_WIDTH.
- The counter and period count never exceed their terminal values.

Decomposition:
- Shared package pwm_seq_pkg holds:
  - the state enum (IDLE, FETCH, RUN, DONE);
  - the default width constants;
  - a function returning the last address for a given ADDRESS_WIDTH.
- One sub-module, pwm_counter (clk, rst, clear, duty, pwm_out, wrap):
  - free-running counter plus compare;
  - wrap pulses for one cycle on the terminal count.
- The sequencer FSM instantiates pwm_counter and drives its clear during FETCH.

Test Plan:
Bench config: DATA_WIDTH=4, ADDRESS_WIDTH=2, PERIODS_PER_STEP=2, ROM = {0x0, 0x4, 0xF, 0x8}.
1. Reset release, enable=0 for 10 cycles -> all outputs 0, rom_ce=0, state IDLE.
2. enable=1, loop_en=0 -> single-cycle rom_ce/read_en pulses at addresses 0,1,2,3, each 33 cycles apart. duty follows 0,4,15,8. pwm_out high counts per step are 0, 8, 30, 16 cycles. done=1 after the last step; pwm_out=0 from then on.
3. Same run with loop_en=1 -> after address 3, the next FETCH uses address 0. done never asserts. The sequence repeats over 2 laps (264 cycles).
4. enable dropped mid-RUN at address 2, counter=7 -> next cycle IDLE, pwm_out=0, address=0, busy=0. Re-enable restarts at address 0.
5. rst=1 asserted in RUN with enable held high -> next edge all outputs 0. When rst falls, FETCH at address 0 starts on the following cycle.
6. From DONE, drop enable then raise it again -> done falls, IDLE for 1 cycle, then FETCH at address 0.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared state encoding, default widths and address helper for the PWM ROM sequencer
package pwm_seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_e;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDRESS_WIDTH = 8;
  localparam int DEF_PERIODS_PER_STEP = 4;
  function automatic int unsigned last_address(input int unsigned aw);
    return (1 << aw) - 1;
  endfunction
endpackage

// File: rtl/pwm_counter.sv
// pwm_counter: free-running PWM counter with registered compare and terminal-count wrap pulse
module pwm_counter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] duty,
  output logic                  pwm_out,
  output logic                  wrap
);
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic pwm_q, pwm_d;
  // duty is the value that will be in force next cycle, so pwm_q lines up with cnt_q
  always_comb begin
    cnt_d = clear ? '0 : cnt_q + 1'b1;
    pwm_d = cnt_d < duty;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end
  assign pwm_out = pwm_q;
  assign wrap = cnt_q == {DATA_WIDTH{1'b1}};
endmodule

// File: rtl/pwm_rom_sequencer.sv
// pwm_rom_sequencer: walks a ROM duty table, holding each entry for a fixed number of PWM periods
module pwm_rom_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int PERIODS_PER_STEP = DEF_PERIODS_PER_STEP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     loop_en,
  output logic                     rom_ce,
  output logic                     rom_read_en,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     pwm_out,
  output logic [DATA_WIDTH-1:0]    duty,
  output logic                     busy,
  output logic                     done
);
  localparam int PW = PERIODS_PER_STEP > 1 ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(PERIODS_PER_STEP - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(last_address(ADDRESS_WIDTH));
  state_e state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] duty_q, duty_d, cnt_duty;
  logic [PW-1:0] pc_q, pc_d;
  logic ce_q, busy_q, done_q, clear, wrap;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    duty_d = duty_q;
    pc_d = pc_q;
    unique case (state_q)
      IDLE:  if (enable) state_d = FETCH;
      FETCH: begin
        state_d = RUN;
        duty_d = rom_data;
        pc_d = '0;
      end
      RUN: if (wrap) begin
        pc_d = pc_q == PC_LAST ? '0 : pc_q + 1'b1;
        if (pc_q == PC_LAST) begin
          state_d = (addr_q == LAST && !loop_en) ? DONE : FETCH;
          addr_d = (addr_q == LAST && !loop_en) ? addr_q : addr_q + 1'b1;
        end
      end
      DONE:  if (!enable) state_d = IDLE;
    endcase
    if (!enable && (state_q == FETCH || state_q == RUN)) state_d = IDLE;
    if (state_d == IDLE) begin
      addr_d = '0;
      duty_d = '0;
      pc_d = '0;
    end
    // counter only advances while staying in RUN; a zero duty forces pwm low elsewhere
    clear = !(state_q == RUN && state_d == RUN);
    cnt_duty = state_d == RUN ? duty_d : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      duty_q <= '0;
      pc_q <= '0;
      ce_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      duty_q <= duty_d;
      pc_q <= pc_d;
      ce_q <= state_d == FETCH;
      busy_q <= state_d == FETCH || state_d == RUN;
      done_q <= state_d == DONE;
    end
  end
  pwm_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .duty(cnt_duty),
    .pwm_out(pwm_out),
    .wrap(wrap)
  );
  assign rom_ce = ce_q;
  assign rom_read_en = ce_q;
  assign rom_address = addr_q;
  assign duty = duty_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_pwm_rom_sequencer.sv
// tb_pwm_rom_sequencer: directed table, corner sequences and randomized run against a step-time model
module tb_pwm_rom_sequencer;
  localparam int STEP = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic loop_en = 1'b0;
  logic rom_ce, rom_read_en, pwm_out, busy, done;
  logic [1:0] rom_address;
  logic [3:0] rom_data, duty;
  logic [3:0] rom [4] = '{4'h0, 4'h4, 4'hF, 4'h8};
  logic [10:0] obs;
  int vectors = 0;
  int miscompares = 0;
  int m_mode = 0, m_t = 0, m_addr = 0, m_duty = 0;

  assign rom_data = rom[rom_address];
  assign obs = {rom_ce, rom_read_en, busy, done, pwm_out, rom_address, duty};

  pwm_rom_sequencer #(.DATA_WIDTH(4), .ADDRESS_WIDTH(2), .PERIODS_PER_STEP(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .loop_en(loop_en),
    .rom_ce(rom_ce), .rom_read_en(rom_read_en), .rom_address(rom_address),
    .rom_data(rom_data), .pwm_out(pwm_out), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, lp;
    int n;
    logic ce, busy, done, pwm;
    logic [1:0] addr;
    logic [3:0] duty;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(logic ce, logic b, logic d, logic p, logic [1:0] a, logic [3:0] du);
    return {ce, ce, b, d, p, a, du};
  endfunction

  // time-indexed reference: m_t=0 is the fetch cycle, m_t=1..STEP are the held-duty cycles
  task automatic model_step(input logic r, input logic e, input logic l);
    if (r) begin
      m_mode = 0; m_addr = 0; m_t = 0; m_duty = 0;
    end else if (m_mode == 0) begin
      if (e) begin m_mode = 1; m_t = 0; m_addr = 0; end
    end else if (!e) begin
      m_mode = 0; m_addr = 0; m_duty = 0; m_t = 0;
    end else if (m_mode == 1) begin
      if (m_t == 0) begin
        m_duty = int'(rom[m_addr]); m_t = 1;
      end else if (m_t == STEP) begin
        if (m_addr == 3 && !l) m_mode = 2;
        else begin m_addr = (m_addr + 1) % 4; m_t = 0; end
      end else m_t++;
    end
  endtask

  function automatic logic [10:0] model_obs();
    logic p;
    p = m_mode == 1 && m_t > 0 && ((m_t - 1) % 16) < m_duty;
    return mk(m_mode == 1 && m_t == 0, m_mode == 1, m_mode == 2, p, 2'(m_addr), 4'(m_duty));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [18];
    int hi [4];
    int fa [$];
    int fc [$];
    int ndone, k;
    logic ok;
    tbl = '{
      '{1,0,0, 2, 0,0,0,0, 0,4'h0},
      '{0,0,0,10, 0,0,0,0, 0,4'h0},
      '{0,1,0, 1, 1,1,0,0, 0,4'h0},
      '{0,1,0, 1, 0,1,0,0, 0,4'h0},
      '{0,1,0,32, 1,1,0,0, 1,4'h0},
      '{0,1,0, 1, 0,1,0,1, 1,4'h4},
      '{0,1,0, 4, 0,1,0,0, 1,4'h4},
      '{0,1,0,28, 1,1,0,0, 2,4'h4},
      '{0,1,0, 1, 0,1,0,1, 2,4'hF},
      '{0,1,0,15, 0,1,0,0, 2,4'hF},
      '{0,1,0, 1, 0,1,0,1, 2,4'hF},
      '{0,1,0,16, 1,1,0,0, 3,4'hF},
      '{0,1,0, 1, 0,1,0,1, 3,4'h8},
      '{0,1,0, 8, 0,1,0,0, 3,4'h8},
      '{0,1,0,24, 0,0,1,0, 3,4'h8},
      '{0,1,0, 5, 0,0,1,0, 3,4'h8},
      '{0,0,0, 1, 0,0,0,0, 0,4'h0},
      '{0,1,0, 1, 1,1,0,0, 0,4'h0}
    };
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; loop_en = tbl[i].lp;
      repeat (tbl[i].n) tick();
      chk($sformatf("table[%0d]", i), 32'(obs),
          32'(mk(tbl[i].ce, tbl[i].busy, tbl[i].done, tbl[i].pwm, tbl[i].addr, tbl[i].duty)));
    end

    // single pass: per-step pwm high counts, fetch order and spacing
    rst = 1; enable = 0; loop_en = 0; tick(); rst = 0; enable = 1;
    hi = '{0, 0, 0, 0};
    k = 0;
    while (!done && k < 200) begin
      tick(); k++;
      if (rom_ce) begin fa.push_back(int'(rom_address)); fc.push_back(k); end
      else if (pwm_out) hi[rom_address]++;
    end
    chk("single_done_reached", 32'(done), 32'd1);
    chk("single_fetch_count", fa.size(), 4);
    for (int i = 0; i < 4 && i < fa.size(); i++) chk($sformatf("single_fetch_addr[%0d]", i), fa[i], i);
    for (int i = 1; i < 4 && i < fc.size(); i++) chk($sformatf("single_fetch_gap[%0d]", i), fc[i] - fc[i-1], 33);
    chk("pwm_high_step0", hi[0], 0);
    chk("pwm_high_step1", hi[1], 8);
    chk("pwm_high_step2", hi[2], 30);
    chk("pwm_high_step3", hi[3], 16);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (pwm_out || !done) ok = 1'b0; end
    chk("done_hold_pwm_low", 32'(ok), 32'd1);

    // looping over two laps
    rst = 1; enable = 0; tick(); rst = 0; enable = 1; loop_en = 1;
    fa.delete(); fc.delete(); ndone = 0;
    for (int c = 1; c <= 264; c++) begin
      tick();
      if (rom_ce) begin fa.push_back(int'(rom_address)); fc.push_back(c); end
      if (done) ndone++;
    end
    chk("loop_fetch_count", fa.size(), 8);
    for (int i = 0; i < 8 && i < fa.size(); i++) chk($sformatf("loop_fetch_addr[%0d]", i), fa[i], i % 4);
    for (int i = 1; i < 8 && i < fc.size(); i++) chk($sformatf("loop_fetch_gap[%0d]", i), fc[i] - fc[i-1], 33);
    chk("loop_done_never", ndone, 0);

    // abort mid-RUN at address 2 with the counter at 7
    rst = 1; enable = 0; loop_en = 0; tick(); rst = 0; enable = 1;
    k = 0;
    while (!(rom_ce && rom_address == 2'd2) && k < 200) begin tick(); k++; end
    chk("abort_reach_addr2", 32'(rom_ce && rom_address == 2'd2), 32'd1);
    repeat (8) tick();
    chk("abort_pre_state", 32'(obs), 32'(mk(0, 1, 0, 1, 2'd2, 4'hF)));
    enable = 0; tick();
    chk("abort_idle", 32'(obs), 32'(mk(0, 0, 0, 0, 2'd0, 4'h0)));
    enable = 1; tick();
    chk("abort_restart_fetch", 32'(obs), 32'(mk(1, 1, 0, 0, 2'd0, 4'h0)));

    // reset during RUN with enable held high
    repeat (5) tick();
    rst = 1; tick();
    chk("reset_in_run", 32'(obs), 32'(mk(0, 0, 0, 0, 2'd0, 4'h0)));
    rst = 0; tick();
    chk("reset_release_fetch", 32'(obs), 32'(mk(1, 1, 0, 0, 2'd0, 4'h0)));

    // randomized run against the reference model
    rst = 1; enable = 0; tick(); model_step(1, 0, 0);
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(999) == 0;
      enable = $urandom_range(249) != 0;
      loop_en = $urandom_range(1);
      tick();
      model_step(rst, enable, loop_en);
      chk($sformatf("random[%0d]", c), 32'(obs), 32'(model_obs()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
